ip_arp_resolver: RTL and testbench

// - Sits upstream of the ARP block, on the IP transmit path. Accepts outgoing IP header

---
 rtl/ip_arp_resolver.sv | 215 +++++++++++++++++++++
 tb/tb_ip_arp_resolver.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ip_arp_resolver.sv
// IP transmit header path: one ARP lookup per header, header emitted with the resolved MAC.
// Define IP_ARP_RESOLVER_MEMO_EN to add a one-entry {ip, mac} memo that skips repeat lookups.
module ip_arp_resolver #(
   parameter int unsigned     META_WIDTH   = 64,
   parameter longint unsigned RESP_TIMEOUT = 64'd125_000_000 * 64'd40,
   parameter int unsigned     TIMER_WIDTH  = 40
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  s_ip_hdr_valid,
   output logic                  s_ip_hdr_ready,
   input  logic [31:0]           s_ip_dest_ip,
   input  logic [META_WIDTH-1:0] s_ip_meta,
   output logic                  m_hdr_valid,
   input  logic                  m_hdr_ready,
   output logic [47:0]           m_eth_dest_mac,
   output logic [31:0]           m_ip_dest_ip,
   output logic [META_WIDTH-1:0] m_ip_meta,
   output logic                  m_hdr_error,
   output logic                  arp_request_valid,
   input  logic                  arp_request_ready,
   output logic [31:0]           arp_request_ip,
   input  logic                  arp_response_valid,
   output logic                  arp_response_ready,
   input  logic                  arp_response_error,
   input  logic [47:0]           arp_response_mac,
   input  logic                  clear_cache,
   output logic [15:0]           error_count
);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StOut} state_e;

   localparam logic [TIMER_WIDTH-1:0] TimerLoad = TIMER_WIDTH'(RESP_TIMEOUT);
   localparam bit                     TimeoutEn = (RESP_TIMEOUT != 64'd0);

   state_e                 state_q, state_d;
   logic                   in_ready_q, in_ready_d;
   logic                   req_valid_q, req_valid_d;
   logic                   rsp_ready_q, rsp_ready_d;
   logic                   out_valid_q, out_valid_d;
   logic [31:0]            dest_ip_q, dest_ip_d;
   logic [META_WIDTH-1:0]  meta_q, meta_d;
   logic [47:0]            mac_q, mac_d;
   logic                   hdr_err_q, hdr_err_d;
   logic [TIMER_WIDTH-1:0] timer_q, timer_d;
   logic [15:0]            err_cnt_q, err_cnt_d;

   logic                   in_hs, req_hs, rsp_hs, out_hs, timed_out;
   logic                   memo_hit;
   logic [47:0]            memo_mac;

   assign in_hs     = in_ready_q && s_ip_hdr_valid;
   assign req_hs    = req_valid_q && arp_request_ready;
   assign rsp_hs    = rsp_ready_q && arp_response_valid;
   assign out_hs    = out_valid_q && m_hdr_ready;
   assign timed_out = TimeoutEn && (timer_q == '0);

`ifdef IP_ARP_RESOLVER_MEMO_EN
   logic        memo_valid_q, memo_valid_d;
   logic [31:0] memo_ip_q, memo_ip_d;
   logic [47:0] memo_mac_q, memo_mac_d;
   logic        memo_wr, memo_kill;

   // A concurrent clear_cache suppresses the hit so the lookup goes to the ARP block.
   assign memo_hit  = memo_valid_q && (memo_ip_q == s_ip_dest_ip) && !clear_cache;
   assign memo_mac  = memo_mac_q;
   assign memo_wr   = (state_q == StWait) && rsp_hs && !arp_response_error;
   assign memo_kill = (state_q == StWait) && ((rsp_hs && arp_response_error) ||
                                              (!rsp_hs && timed_out));

   always_comb begin
      memo_valid_d = memo_valid_q;
      memo_ip_d    = memo_ip_q;
      memo_mac_d   = memo_mac_q;
      if (memo_wr) begin
         memo_valid_d = 1'b1;
         memo_ip_d    = dest_ip_q;
         memo_mac_d   = arp_response_mac;
      end
      if (memo_kill && (memo_ip_q == dest_ip_q)) begin
         memo_valid_d = 1'b0;
      end
      if (clear_cache) begin
         memo_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         memo_valid_q <= 1'b0;
         memo_ip_q    <= '0;
         memo_mac_q   <= '0;
      end else begin
         memo_valid_q <= memo_valid_d;
         memo_ip_q    <= memo_ip_d;
         memo_mac_q   <= memo_mac_d;
      end
   end
`else
   logic unused_clear_cache;

   assign unused_clear_cache = clear_cache;
   assign memo_hit           = 1'b0;
   assign memo_mac           = '0;
`endif

   always_comb begin
      state_d     = state_q;
      in_ready_d  = in_ready_q;
      req_valid_d = req_valid_q;
      rsp_ready_d = 1'b1;
      out_valid_d = out_valid_q;
      dest_ip_d   = dest_ip_q;
      meta_d      = meta_q;
      mac_d       = mac_q;
      hdr_err_d   = hdr_err_q;
      timer_d     = timer_q;
      err_cnt_d   = err_cnt_q;

      unique case (state_q)
         StIdle: begin
            in_ready_d = 1'b1;
            if (in_hs) begin
               in_ready_d = 1'b0;
               dest_ip_d  = s_ip_dest_ip;
               meta_d     = s_ip_meta;
               if (memo_hit) begin
                  mac_d       = memo_mac;
                  hdr_err_d   = 1'b0;
                  out_valid_d = 1'b1;
                  state_d     = StOut;
               end else begin
                  req_valid_d = 1'b1;
                  state_d     = StReq;
               end
            end
         end
         StReq: begin
            if (req_hs) begin
               req_valid_d = 1'b0;
               timer_d     = TimerLoad;
               state_d     = StWait;
            end
         end
         StWait: begin
            if (timer_q != '0) begin
               timer_d = timer_q - TIMER_WIDTH'(1);
            end
            // A response in the same cycle as expiry takes priority over the timeout.
            if (rsp_hs) begin
               mac_d       = arp_response_error ? 48'h0 : arp_response_mac;
               hdr_err_d   = arp_response_error;
               out_valid_d = 1'b1;
               state_d     = StOut;
            end else if (timed_out) begin
               mac_d       = 48'h0;
               hdr_err_d   = 1'b1;
               out_valid_d = 1'b1;
               state_d     = StOut;
            end
         end
         StOut: begin
            if (out_hs) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = StIdle;
               if (hdr_err_q && (err_cnt_q != 16'hFFFF)) begin
                  err_cnt_d = err_cnt_q + 16'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         in_ready_q  <= 1'b0;
         req_valid_q <= 1'b0;
         rsp_ready_q <= 1'b0;
         out_valid_q <= 1'b0;
         dest_ip_q   <= '0;
         meta_q      <= '0;
         mac_q       <= '0;
         hdr_err_q   <= 1'b0;
         timer_q     <= '0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         req_valid_q <= req_valid_d;
         rsp_ready_q <= rsp_ready_d;
         out_valid_q <= out_valid_d;
         dest_ip_q   <= dest_ip_d;
         meta_q      <= meta_d;
         mac_q       <= mac_d;
         hdr_err_q   <= hdr_err_d;
         timer_q     <= timer_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign s_ip_hdr_ready     = in_ready_q;
   assign m_hdr_valid        = out_valid_q;
   assign m_eth_dest_mac     = mac_q;
   assign m_ip_dest_ip       = dest_ip_q;
   assign m_ip_meta          = meta_q;
   assign m_hdr_error        = hdr_err_q;
   assign arp_request_valid  = req_valid_q;
   assign arp_request_ip     = dest_ip_q;
   assign arp_response_ready = rsp_ready_q;
   assign error_count        = err_cnt_q;

endmodule

// File: tb/tb_ip_arp_resolver.sv
// Self-checking bench for ip_arp_resolver: directed cases then randomized headers against a
// transaction-level model of the expected output header, error count and memo.
module tb_ip_arp_resolver;

   localparam int TMO = 16;
`ifdef IP_ARP_RESOLVER_MEMO_EN
   localparam bit MEMO = 1'b1;
`else
   localparam bit MEMO = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        s_ip_hdr_valid;
   logic        s_ip_hdr_ready;
   logic [31:0] s_ip_dest_ip;
   logic [63:0] s_ip_meta;
   logic        m_hdr_valid;
   logic        m_hdr_ready;
   logic [47:0] m_eth_dest_mac;
   logic [31:0] m_ip_dest_ip;
   logic [63:0] m_ip_meta;
   logic        m_hdr_error;
   logic        arp_request_valid;
   logic        arp_request_ready;
   logic [31:0] arp_request_ip;
   logic        arp_response_valid;
   logic        arp_response_ready;
   logic        arp_response_error;
   logic [47:0] arp_response_mac;
   logic        clear_cache;
   logic [15:0] error_count;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   bit          memo_v   = 1'b0;
   logic [31:0] memo_ip  = '0;
   logic [47:0] memo_mac = '0;
   int          exp_cnt  = 0;

   ip_arp_resolver #(
      .META_WIDTH  (64),
      .RESP_TIMEOUT(64'(TMO)),
      .TIMER_WIDTH (40)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .s_ip_hdr_valid    (s_ip_hdr_valid),
      .s_ip_hdr_ready    (s_ip_hdr_ready),
      .s_ip_dest_ip      (s_ip_dest_ip),
      .s_ip_meta         (s_ip_meta),
      .m_hdr_valid       (m_hdr_valid),
      .m_hdr_ready       (m_hdr_ready),
      .m_eth_dest_mac    (m_eth_dest_mac),
      .m_ip_dest_ip      (m_ip_dest_ip),
      .m_ip_meta         (m_ip_meta),
      .m_hdr_error       (m_hdr_error),
      .arp_request_valid (arp_request_valid),
      .arp_request_ready (arp_request_ready),
      .arp_request_ip    (arp_request_ip),
      .arp_response_valid(arp_response_valid),
      .arp_response_ready(arp_response_ready),
      .arp_response_error(arp_response_error),
      .arp_response_mac  (arp_response_mac),
      .clear_cache       (clear_cache),
      .error_count       (error_count)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog obs=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_in_ready"}, s_ip_hdr_ready, 0);
      chk({tag, "_out_valid"}, m_hdr_valid, 0);
      chk({tag, "_mac"}, m_eth_dest_mac, 0);
      chk({tag, "_ip"}, m_ip_dest_ip, 0);
      chk({tag, "_meta"}, m_ip_meta, 0);
      chk({tag, "_err"}, m_hdr_error, 0);
      chk({tag, "_req_valid"}, arp_request_valid, 0);
      chk({tag, "_req_ip"}, arp_request_ip, 0);
      chk({tag, "_rsp_ready"}, arp_response_ready, 0);
      chk({tag, "_err_cnt"}, error_count, 0);
   endtask

   task automatic wait_in_ready();
      int n = 0;
      while (s_ip_hdr_ready !== 1'b1 && n < 50) begin
         step();
         n++;
      end
      chk("in_ready_wait", s_ip_hdr_ready, 1);
   endtask

   // rsp_at: edge index after the request handshake at which the response is sampled;
   // anything beyond TMO+1 means no response before the timeout.
   task automatic do_header(input logic [31:0] ip, input logic [63:0] meta, input int req_delay,
                            input int rsp_at, input bit rsp_err, input logic [47:0] rsp_mac,
                            input int out_delay, input bit clr_with);
      bit          hit;
      bit          tmo;
      logic [47:0] exp_mac;
      bit          exp_err;
      wait_in_ready();
      s_ip_hdr_valid = 1'b1;
      s_ip_dest_ip   = ip;
      s_ip_meta      = meta;
      clear_cache    = clr_with;
      hit = MEMO && memo_v && (memo_ip == ip) && !clr_with;
      if (clr_with) memo_v = 1'b0;
      step();
      s_ip_hdr_valid = 1'b0;
      clear_cache    = 1'b0;
      s_ip_dest_ip   = $urandom;
      s_ip_meta      = {$urandom, $urandom};
      chk("in_ready_drop", s_ip_hdr_ready, 0);
      if (hit) begin
         exp_mac = memo_mac;
         exp_err = 1'b0;
         chk("hit_no_req", arp_request_valid, 0);
      end else begin
         chk("req_valid", arp_request_valid, 1);
         chk("req_ip", arp_request_ip, ip);
         for (int i = 0; i < req_delay; i++) begin
            step();
            chk("req_hold_valid", arp_request_valid, 1);
            chk("req_hold_ip", arp_request_ip, ip);
            chk("req_hold_in_ready", s_ip_hdr_ready, 0);
         end
         arp_request_ready = 1'b1;
         step();
         arp_request_ready = 1'b0;
         chk("req_drop", arp_request_valid, 0);
         tmo = (rsp_at > TMO + 1);
         for (int c = 1; c <= TMO + 1; c++) begin
            if (c == rsp_at) begin
               arp_response_valid = 1'b1;
               arp_response_error = rsp_err;
               arp_response_mac   = rsp_mac;
            end
            step();
            arp_response_valid = 1'b0;
            if (c == rsp_at || c == TMO + 1) break;
            chk("wait_no_out", m_hdr_valid, 0);
         end
         if (tmo || rsp_err) begin
            exp_mac = '0;
            exp_err = 1'b1;
            if (memo_ip == ip) memo_v = 1'b0;
         end else begin
            exp_mac  = rsp_mac;
            exp_err  = 1'b0;
            memo_v   = 1'b1;
            memo_ip  = ip;
            memo_mac = rsp_mac;
         end
      end
      chk("out_valid", m_hdr_valid, 1);
      chk("out_mac", m_eth_dest_mac, exp_mac);
      chk("out_err", m_hdr_error, exp_err);
      chk("out_ip", m_ip_dest_ip, ip);
      chk("out_meta", m_ip_meta, meta);
      for (int i = 0; i < out_delay; i++) begin
         step();
         chk("out_hold_valid", m_hdr_valid, 1);
         chk("out_hold_mac", m_eth_dest_mac, exp_mac);
         chk("out_hold_meta", m_ip_meta, meta);
         chk("out_hold_in_ready", s_ip_hdr_ready, 0);
      end
      m_hdr_ready = 1'b1;
      step();
      m_hdr_ready = 1'b0;
      if (exp_err && exp_cnt < 16'hFFFF) exp_cnt++;
      chk("out_drop", m_hdr_valid, 0);
      chk("in_ready_back", s_ip_hdr_ready, 1);
      chk("err_count", error_count, 16'(exp_cnt));
      if (!hit && tmo) begin
         // late response for the timed-out lookup must be drained silently
         arp_response_valid = 1'b1;
         arp_response_error = 1'b0;
         arp_response_mac   = 48'hDEAD_BEEF_0001;
         step();
         arp_response_valid = 1'b0;
         chk("stale_rsp_ready", arp_response_ready, 1);
         step();
         chk("stale_no_out", m_hdr_valid, 0);
         chk("stale_no_req", arp_request_valid, 0);
      end
   endtask

   initial begin
      rst                = 1'b1;
      s_ip_hdr_valid     = 1'b0;
      s_ip_dest_ip       = '0;
      s_ip_meta          = '0;
      m_hdr_ready        = 1'b0;
      arp_request_ready  = 1'b0;
      arp_response_valid = 1'b0;
      arp_response_error = 1'b0;
      arp_response_mac   = '0;
      clear_cache        = 1'b0;
      repeat (3) step();
      chk_all_zero("reset");
      rst = 1'b0;
      step();
      chk("post_reset_in_ready", s_ip_hdr_ready, 1);
      chk("post_reset_rsp_ready", arp_response_ready, 1);

      // T1 basic
      do_header(32'h0A00_0005, 64'h0123_4567_89AB_CDEF, 0, 2, 1'b0, 48'h02_00_00_00_00_05, 0,
                1'b0);
      // T2 ARP error
      do_header(32'h0A00_0006, 64'hFEDC_BA98_7654_3210, 0, 3, 1'b1, 48'h02_00_00_00_00_06, 0,
                1'b0);
      chk("t2_err_count", error_count, 1);
      // T3 timeout then a normal header
      do_header(32'h0A00_0007, 64'h1111_2222_3333_4444, 0, 99, 1'b0, 48'h0, 0, 1'b0);
      do_header(32'h0A00_0008, 64'h5555_6666_7777_8888, 0, 1, 1'b0, 48'h02_00_00_00_00_08, 0,
                1'b0);
      // T4 backpressure on both sides
      do_header(32'h0A00_0009, 64'h9999_AAAA_BBBB_CCCC, 10, 4, 1'b0, 48'h02_00_00_00_00_09, 8,
                1'b0);

      // T5 reset mid-WAIT
      wait_in_ready();
      s_ip_hdr_valid = 1'b1;
      s_ip_dest_ip   = 32'h0A00_000A;
      s_ip_meta      = 64'hABCD;
      step();
      s_ip_hdr_valid    = 1'b0;
      arp_request_ready = 1'b1;
      step();
      arp_request_ready = 1'b0;
      repeat (3) step();
      rst = 1'b1;
      step();
      chk_all_zero("t5_rst");
      rst     = 1'b0;
      exp_cnt = 0;
      memo_v  = 1'b0;
      step();
      chk("t5_in_ready", s_ip_hdr_ready, 1);
      arp_response_valid = 1'b1;
      arp_response_mac   = 48'h02_00_00_00_00_0A;
      step();
      arp_response_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t5_no_out", m_hdr_valid, 0);
      end

      // T6 memo sequence (plain lookups when the memo is absent)
      do_header(32'h0A00_0005, 64'h1, 0, 2, 1'b0, 48'h02_00_00_00_00_05, 0, 1'b0);
      do_header(32'h0A00_0005, 64'h2, 0, 2, 1'b0, 48'h02_00_00_00_00_05, 0, 1'b0);
      clear_cache = 1'b1;
      step();
      clear_cache = 1'b0;
      memo_v      = 1'b0;
      do_header(32'h0A00_0005, 64'h3, 0, 2, 1'b0, 48'h02_00_00_00_00_05, 0, 1'b0);
      do_header(32'h0A00_0005, 64'h4, 0, 2, 1'b0, 48'h02_00_00_00_00_05, 0, 1'b1);

      // Randomized headers over a small address set so memo hits occur
      for (int n = 0; n < 40; n++) begin
         logic [31:0] ip;
         ip = 32'h0A00_0005 + 32'($urandom_range(0, 2));
         if ($urandom_range(0, 7) == 0) begin
            clear_cache = 1'b1;
            step();
            clear_cache = 1'b0;
            memo_v      = 1'b0;
         end
         do_header(ip, {$urandom, $urandom}, $urandom_range(0, 4), $urandom_range(1, 22),
                   ($urandom_range(0, 3) == 0), {16'h0200, $urandom}, $urandom_range(0, 4),
                   ($urandom_range(0, 7) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
